// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU sequencing controller:
// ALU control-line encodings, request opcodes and the controller state type.
package alu_ctrl_pkg;

  localparam logic [2:0] GIN_AND  = 3'b000;
  localparam logic [2:0] GIN_OR   = 3'b001;
  localparam logic [2:0] GIN_ADD  = 3'b010;
  localparam logic [2:0] GIN_SUB  = 3'b110;
  localparam logic [2:0] GIN_SLT  = 3'b111;

  localparam logic [2:0] OP_MULLO = 3'b011;
  localparam logic [2:0] OP_RSV0  = 3'b100;
  localparam logic [2:0] OP_RSV1  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic op_reserved(input logic [2:0] op);
    return (op == OP_RSV0) || (op == OP_RSV1);
  endfunction

  // Only the arithmetic ops produce a meaningful vout; the others leave it stale.
  function automatic logic op_has_ovf(input logic [2:0] op);
    return (op == GIN_ADD) || (op == GIN_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer in front of the combinational MIPS-lite ALU.
// Pass-through ops take one ALU cycle; MULLO iterates the ALU's ADD MUL_ITER times.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_ITER = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_gin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_zout,
  input  logic             alu_vout
);

  localparam int              CNT_W    = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       op_lat;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand_sh;
  logic [WIDTH-1:0] mplier_sh;
  logic             mul_last;

  assign mcand_sh  = mcand << 1;
  assign mplier_sh = mplier >> 1;
  assign mul_last  = (cnt == CNT_LAST);

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (op_reserved(req_op))     state_nxt = ST_RESP;
          else if (req_op == OP_MULLO) state_nxt = ST_MUL;
          else                         state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_MUL:  if (mul_last) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU ports are registered, so they are loaded on the edge that enters EXEC/MUL
  // and on every MUL iteration, which keeps the ALU settled for the whole cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_lat     <= GIN_AND;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_gin    <= GIN_AND;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_lat <= req_op;
            if (op_reserved(req_op)) begin
              rsp_result <= '0;
              rsp_zero   <= 1'b1;
              rsp_ovf    <= 1'b0;
              rsp_err    <= 1'b1;
            end else if (req_op == OP_MULLO) begin
              acc     <= '0;
              mcand   <= req_a;
              mplier  <= req_b;
              cnt     <= '0;
              alu_a   <= '0;
              alu_b   <= req_b[0] ? req_a : '0;
              alu_gin <= GIN_ADD;
            end else begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_gin <= req_op;
            end
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_sum;
          rsp_zero   <= alu_zout;
          rsp_ovf    <= op_has_ovf(op_lat) & alu_vout;
          rsp_err    <= 1'b0;
          alu_a      <= '0;
          alu_b      <= '0;
          alu_gin    <= GIN_AND;
        end
        ST_MUL: begin
          acc    <= alu_sum;
          mcand  <= mcand_sh;
          mplier <= mplier_sh;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            rsp_result <= alu_sum;
            rsp_zero   <= (alu_sum == '0);
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_gin    <= GIN_AND;
          end else begin
            alu_a <= alu_sum;
            alu_b <= mplier_sh[0] ? mcand_sh : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU (stale vout on logic ops)
// and a plain-arithmetic reference model for every opcode.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_gin;
  logic [31:0] alu_sum;
  logic        alu_zout, alu_vout;

  alu_seq_ctrl #(.WIDTH(32), .MUL_ITER(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin),
    .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_vout(alu_vout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: vout is only refreshed by ADD/SUB and otherwise holds its last value.
  logic v_comb;
  logic v_stale = 1'b0;
  always_comb begin
    alu_sum = '0;
    v_comb  = 1'b0;
    case (alu_gin)
      3'b000: alu_sum = alu_a & alu_b;
      3'b001: alu_sum = alu_a | alu_b;
      3'b010: begin
        alu_sum = alu_a + alu_b;
        v_comb  = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      3'b110: begin
        alu_sum = alu_a - alu_b;
        v_comb  = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
      end
      3'b111: alu_sum = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_sum = '0;
    endcase
  end
  always @(posedge clk) if (alu_gin == 3'b010 || alu_gin == 3'b110) v_stale <= v_comb;
  assign alu_zout = (alu_sum == 32'd0);
  assign alu_vout = (alu_gin == 3'b010 || alu_gin == 3'b110) ? v_comb : v_stale;

  typedef struct {
    logic [31:0] r;
    logic        z, o, e;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int acc_cyc);
    exp_t   x;
    longint s;
    x.r = '0; x.z = 1'b0; x.o = 1'b0; x.e = 1'b0; x.lat = 2; x.acc = acc_cyc;
    case (op)
      3'd0: x.r = a & b;
      3'd1: x.r = a | b;
      3'd2: begin
        x.r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd6: begin
        x.r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        x.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd7: x.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: begin
        x.r = 32'((64'(a) * 64'(b)) & 64'hFFFF_FFFF);
        x.lat = 33;
      end
      default: begin
        x.e = 1'b1;
        x.lat = 1;
      end
    endcase
    x.z = (x.r == 32'd0);
    return x;
  endfunction

  // Monitor: pops on every response handshake, checks stability while held.
  logic        prev_v = 1'b0;
  logic [31:0] prev_r;
  logic [2:0]  prev_f;
  int          rise_cyc = 0;
  int          hs_cyc = -10;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid) begin
        chk("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
        chk("alu_idle_in_resp", {alu_a ^ alu_b, 29'd0, alu_gin} | {alu_a, 3'd0}, 35'd0);
        if (!prev_v) rise_cyc = cyc;
        else begin
          chk("held_result", rsp_result, prev_r);
          chk("held_flags", {29'd0, rsp_zero, rsp_ovf, rsp_err}, {29'd0, prev_f});
        end
      end
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("rsp_result", rsp_result, x.r);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, x.z});
          chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, x.o});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
          chk("rsp_latency", 32'(rise_cyc - x.acc), 32'(x.lat));
        end
      end
      prev_v = rsp_valid;
      prev_r = rsp_result;
      prev_f = {rsp_zero, rsp_ovf, rsp_err};
    end
  end

  // Response-ready driver: held low, random, or always high.
  logic bp_hold = 1'b0;
  logic rand_bp = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = bp_hold ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  int last_acc = 0;
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit done = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(model(op, a, b, cyc));
        last_acc = cyc;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_result"}, rsp_result, 32'd0);
    chk({tag, "_rsp_flags"}, {29'd0, rsp_zero, rsp_ovf, rsp_err}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_gin"}, {29'd0, alu_gin}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] c [5];
    c[0] = 32'h0; c[1] = 32'hFFFF_FFFF; c[2] = 32'h7FFF_FFFF; c[3] = 32'h8000_0000; c[4] = 32'h1;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    bit seen;
    #2 reset = 1'b1;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_held");
    reset = 1'b0;

    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    issue(3'b110, 32'd5, 32'd5);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    issue(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    issue(3'b011, 32'h0001_0001, 32'h0001_0003);
    issue(3'b011, 32'h8000_0000, 32'h2);
    issue(3'b100, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    chk("reserved_alu_gin", {29'd0, alu_gin}, 32'd0);
    issue(3'b101, 32'h1, 32'h1);
    wait_drain();

    // Backpressure with a pending request behind the held response.
    bp_hold = 1'b1;
    issue(3'b010, 32'h1234_0000, 32'h0000_5678);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
    #1;
    req_valid = 1'b1; req_op = 3'b001; req_a = 32'hA5; req_b = 32'h5A00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    bp_hold = 1'b0;
    issue(3'b001, 32'hA5, 32'h5A00);
    chk("bp_accept_after_hs", 32'(last_acc), 32'(hs_cyc + 1));
    wait_drain();

    rand_bp = 1'b1;
    for (int n = 0; n < 60; n++) issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
    wait_drain();
    rand_bp = 1'b0;

    // Abort a multiply at iteration 15.
    issue(3'b011, 32'h1234_5678, 32'h9ABC_DEF1);
    repeat (14) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("abort_no_rsp", {31'd0, seen}, 32'd0);
    issue(3'b001, 32'hF0, 32'h0F);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
